// File: rtl/soc_bus_arbiter.sv
// Two-master stb/ack bus arbiter, one outstanding transaction.
// Optional ack timeout enabled by defining ARB_TIMEOUT_EN.
module soc_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_wstrb,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wstrb,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    input  logic              i_s_ack,
    input  logic [DATA_W-1:0] i_s_rdata,
    output logic              o_bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;
    logic   stb_q,   stb_d;
    logic   busy;
    logic   done;
    logic   tmo_fire;
    logic   bus_err_q;

    assign busy = (state_q == BUSY);
    assign done = busy && (i_s_ack || tmo_fire);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // A slave ack in the same cycle always beats the timeout.
    assign tmo_fire = busy && !i_s_ack && (cnt_q == CNT_LAST);

    // Count unacknowledged BUSY cycles; held at zero while IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (!busy) begin
            cnt_q <= '0;
        end else if (!i_s_ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus_err_q <= 1'b0;
        end else if (tmo_fire) begin
            bus_err_q <= 1'b1;
        end
    end
`else
    assign tmo_fire  = 1'b0;
    assign bus_err_q = 1'b0;
`endif

    // State, grant and slave strobe registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
        end
    end

    // Arbitrate in IDLE; wait for ack or timeout in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        stb_d   = stb_q;
        unique case (state_q)
            IDLE: begin
                if (i_m0_stb || i_m1_stb) begin
                    state_d = BUSY;
                    stb_d   = 1'b1;
                    if (i_m0_stb && i_m1_stb) begin
                        grant_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
                    end else begin
                        grant_d = i_m1_stb;
                    end
                end
            end
            BUSY: begin
                if (i_s_ack || tmo_fire) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    last_d  = grant_q;
                end
            end
        endcase
    end

    // Request fields follow the granted master.
    assign o_s_stb   = stb_q;
    assign o_s_we    = grant_q ? i_m1_we    : i_m0_we;
    assign o_s_addr  = grant_q ? i_m1_addr  : i_m0_addr;
    assign o_s_wdata = grant_q ? i_m1_wdata : i_m0_wdata;
    assign o_s_wstrb = grant_q ? i_m1_wstrb : i_m0_wstrb;

    // Completion is combinational with the slave ack.
    assign o_m0_ack = done && !grant_q;
    assign o_m1_ack = done &&  grant_q;
    assign o_m0_err = tmo_fire && !grant_q;
    assign o_m1_err = tmo_fire &&  grant_q;

    assign o_m0_rdata = (busy && !grant_q && !tmo_fire) ? i_s_rdata : '0;
    assign o_m1_rdata = (busy &&  grant_q && !tmo_fire) ? i_s_rdata : '0;

    assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter (round-robin and fixed priority).
// Timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_soc_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        m0_stb, m1_stb, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ack;
    logic [31:0] s_rdata;

    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_stb, s_we, bus_err;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic        f_m0_stb, f_m1_stb, f_s_ack;
    logic        f_m0_ack, f_m1_ack, f_m0_err, f_m1_err;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_s_stb, f_s_we, f_bus_err;
    logic [31:0] f_s_addr, f_s_wdata;
    logic [3:0]  f_s_wstrb;

    always #5 clk = ~clk;

    soc_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_wstrb(m0_wstrb),
        .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
        .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
        .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
        .i_s_ack(s_ack), .i_s_rdata(s_rdata), .o_bus_err(bus_err)
    );

    soc_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(8)
    ) dut_fp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_stb(f_m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_wstrb(m0_wstrb),
        .o_m0_ack(f_m0_ack), .o_m0_rdata(f_m0_rdata), .o_m0_err(f_m0_err),
        .i_m1_stb(f_m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
        .o_m1_ack(f_m1_ack), .o_m1_rdata(f_m1_rdata), .o_m1_err(f_m1_err),
        .o_s_stb(f_s_stb), .o_s_we(f_s_we), .o_s_addr(f_s_addr),
        .o_s_wdata(f_s_wdata), .o_s_wstrb(f_s_wstrb),
        .i_s_ack(f_s_ack), .i_s_rdata(s_rdata), .o_bus_err(f_bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m0_stb = 0; m1_stb = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_wstrb = '0; m1_wstrb = '0;
        s_ack = 0; s_rdata = '0;
        f_m0_stb = 0; f_m1_stb = 0; f_s_ack = 0;
        tick();
        tick();
        smp();
        checks++;
        if ({s_stb, m0_ack, m1_ack, m0_err, m1_err, bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {s_stb, m0_ack, m1_ack, m0_err, m1_err, bus_err});
        end
        checks++;
        if ({f_s_stb, f_m0_ack, f_m1_ack} !== 3'b0) begin
            errors++;
            $display("FAIL reset_fp_outputs: got %b expected 000",
                     {f_s_stb, f_m0_ack, f_m1_ack});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        m0_stb = 1; m0_we = 0; m0_addr = 32'h0000_0100;
        smp();
        checks++;
        if (s_stb !== 1'b0) begin
            errors++;
            $display("FAIL read_idle_stb: got %b expected 0", s_stb);
        end
        tick();
        s_ack = 1; s_rdata = 32'hDEAD_BEEF;
        smp();
        checks++;
        if ({s_stb, m0_ack, m1_ack, s_we} !== 4'b1100) begin
            errors++;
            $display("FAIL read_busy_ctl: got %b expected 1100",
                     {s_stb, m0_ack, m1_ack, s_we});
        end
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF || s_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL read_data: got %h/%h expected deadbeef/00000100",
                     m0_rdata, s_addr);
        end
        checks++;
        if (m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL read_m1_rdata: got %h expected 0", m1_rdata);
        end
        tick();
        m0_stb = 0; s_ack = 0;
        smp();
        checks++;
        if ({s_stb, m0_ack} !== 2'b00) begin
            errors++;
            $display("FAIL read_after: got %b expected 00", {s_stb, m0_ack});
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        do_reset();
        m0_stb = 1; m1_stb = 1;
        for (int k = 0; k < 4; k++) begin
            exp = k[0] ? 2'b10 : 2'b01;
            smp();
            checks++;
            if (s_stb !== 1'b0) begin
                errors++;
                $display("FAIL rr_bubble_%0d: got %b expected 0", k, s_stb);
            end
            tick();
            smp();
            checks++;
            if ({s_stb, m1_ack, m0_ack} !== 3'b100) begin
                errors++;
                $display("FAIL rr_wait_%0d: got %b expected 100",
                         k, {s_stb, m1_ack, m0_ack});
            end
            tick();
            tick();
            s_ack = 1;
            smp();
            checks++;
            if ({m1_ack, m0_ack} !== exp) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b expected %b",
                         k, {m1_ack, m0_ack}, exp);
            end
            tick();
            s_ack = 0;
        end
        m0_stb = 0; m1_stb = 0;
        tick();
    endtask

    task automatic test_fixed_prio;
        logic [1:0] exp;
        do_reset();
        f_m0_stb = 1; f_m1_stb = 1;
        for (int k = 0; k < 4; k++) begin
            exp = (k < 3) ? 2'b10 : 2'b01;
            smp();
            checks++;
            if (f_s_stb !== 1'b0) begin
                errors++;
                $display("FAIL fp_bubble_%0d: got %b expected 0", k, f_s_stb);
            end
            tick();
            f_s_ack = 1;
            smp();
            checks++;
            if ({f_m1_ack, f_m0_ack} !== exp) begin
                errors++;
                $display("FAIL fp_grant_%0d: got %b expected %b",
                         k, {f_m1_ack, f_m0_ack}, exp);
            end
            tick();
            f_s_ack = 0;
            if (k == 2) f_m1_stb = 0;
        end
        f_m0_stb = 0;
        tick();
    endtask

    task automatic test_write;
        do_reset();
        m0_addr = 32'h0000_0100; m0_wdata = 32'h0; m0_wstrb = 4'hF;
        m1_stb = 1; m1_we = 1; m1_addr = 32'h8000_0000;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        tick();
        smp();
        checks++;
        if ({s_stb, s_we} !== 2'b11) begin
            errors++;
            $display("FAIL wr_ctl: got %b expected 11", {s_stb, s_we});
        end
        checks++;
        if (s_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL wr_addr: got %h expected 80000000", s_addr);
        end
        checks++;
        if (s_wdata !== 32'h1234_5678 || s_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL wr_data: got %h/%b expected 12345678/0011",
                     s_wdata, s_wstrb);
        end
        tick();
        s_ack = 1;
        smp();
        checks++;
        if ({m1_ack, m0_ack} !== 2'b10) begin
            errors++;
            $display("FAIL wr_ack: got %b expected 10", {m1_ack, m0_ack});
        end
        tick();
        s_ack = 0; m1_stb = 0; m1_we = 0;
        tick();
    endtask

    task automatic test_idle_ack;
        do_reset();
        s_ack = 1;
        smp();
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack: got %b expected 000",
                     {s_stb, m0_ack, m1_ack});
        end
        tick();
        smp();
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack2: got %b expected 000",
                     {s_stb, m0_ack, m1_ack});
        end
        tick();
        s_ack = 0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_stb = 1;
        tick();
        s_ack = 1;
        tick();
        s_ack = 0;
        tick();
        smp();
        checks++;
        if (s_stb !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b expected 1", s_stb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_stb, m0_ack, m1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL mid_async: got %b expected 000",
                     {s_stb, m0_ack, m1_ack});
        end
        tick();
        rst_n = 1'b1;
        m0_stb = 1; m1_stb = 1;
        tick();
        s_ack = 1;
        smp();
        checks++;
        if ({m1_ack, m0_ack} !== 2'b01) begin
            errors++;
            $display("FAIL mid_tie: got %b expected 01", {m1_ack, m0_ack});
        end
        tick();
        s_ack = 0; m0_stb = 0; m1_stb = 0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        m0_stb = 1; s_rdata = 32'hCAFE_F00D;
        tick();
        for (int i = 1; i < 8; i++) begin
            smp();
            checks++;
            if ({m0_ack, m0_err, bus_err} !== 3'b000) begin
                errors++;
                $display("FAIL tmo_wait_%0d: got %b expected 000",
                         i, {m0_ack, m0_err, bus_err});
            end
            tick();
        end
        smp();
        checks++;
        if ({s_stb, m0_ack, m0_err, m1_ack, bus_err} !== 5'b11100) begin
            errors++;
            $display("FAIL tmo_fire: got %b expected 11100",
                     {s_stb, m0_ack, m0_err, m1_ack, bus_err});
        end
        checks++;
        if (m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_rdata: got %h expected 0", m0_rdata);
        end
        tick();
        m0_stb = 0;
        smp();
        checks++;
        if ({s_stb, bus_err} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_after: got %b expected 01", {s_stb, bus_err});
        end
        s_ack = 1;
        tick();
        smp();
        checks++;
        if ({m0_ack, m0_err, bus_err} !== 3'b001) begin
            errors++;
            $display("FAIL tmo_late_ack: got %b expected 001",
                     {m0_ack, m0_err, bus_err});
        end
        tick();
        s_ack = 0;
    endtask
`else
    task automatic test_no_timeout;
        do_reset();
        m0_stb = 1;
        repeat (20) tick();
        smp();
        checks++;
        if ({s_stb, m0_ack, m0_err, bus_err} !== 4'b1000) begin
            errors++;
            $display("FAIL no_tmo_wait: got %b expected 1000",
                     {s_stb, m0_ack, m0_err, bus_err});
        end
        tick();
        s_ack = 1;
        smp();
        checks++;
        if ({m0_ack, m0_err} !== 2'b10) begin
            errors++;
            $display("FAIL no_tmo_ack: got %b expected 10", {m0_ack, m0_err});
        end
        tick();
        s_ack = 0; m0_stb = 0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write();
        test_idle_ack();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
